// File: rtl/daq_pkg.sv
// Shared definitions for the SPI ADC capture path: transmitter state
// encoding, default clock/baud rates and the host sync header byte.
// Reused by the ADC front end, the UART transmitter and the host parser.
package daq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LATCH = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam int unsigned CLK_FREQ_DEF  = 100_000_000;
    localparam int unsigned BAUD_RATE_DEF = 115_200;
    localparam logic [7:0]  HEADER_BYTE   = 8'hA5;

    // Whole clocks per UART bit; any remainder is dropped.
    function automatic int unsigned bit_cycles(input int unsigned freq,
                                               input int unsigned baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART TX/RX.
// Ports:
//   clk, reset : system clock, async active-high reset
//   clr        : synchronous clear, restarts the bit period
//   tick       : high on the last clock of each BIT_CYCLES-long period
module uart_baud_tick #(
    parameter int unsigned BIT_CYCLES = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the ADC byte FIFO and sends each byte as 8N1 (or 8N2) UART.
// With HEADER_EN set, a sync header precedes every lo/hi byte pair.
// Ports:
//   clk, reset  : system clock, async active-high reset
//   fifo_empty  : FIFO empty flag, sampled only while idle
//   fifo_dout   : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  : one-cycle read strobe
//   tx          : serial output, idles high
//   busy        : high whenever not idle
//   byte_done   : pulse on the last clock of each frame's final stop bit
module fifo_uart_tx
    import daq_pkg::*;
#(
    parameter int unsigned clk_freq  = CLK_FREQ_DEF,
    parameter int unsigned baud_rate = BAUD_RATE_DEF,
    parameter int unsigned STOP_BITS = 1,
    parameter int unsigned HEADER_EN = 1,
    parameter logic [7:0]  HEADER    = HEADER_BYTE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int unsigned BIT_CYCLES = bit_cycles(clk_freq, baud_rate);
    localparam logic [2:0]  STOP_LAST  = 3'(STOP_BITS - 1);

    state_t     state, state_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [2:0] bit_cnt, bit_nxt;
    logic       pair, pair_nxt;
    // Header already sent for the pair now pending; without it an idle
    // state with pair=0 would keep re-sending the header forever.
    logic       hdr_sent, hdr_nxt;
    logic       tx_nxt;
    logic       tick;
    logic       baud_clr;

    // Restart the bit period on every state change; within DATA/STOP the
    // counter wraps by itself on each tick.
    assign baud_clr = (state_nxt != state);

    uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr   (baud_clr),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        pair_nxt  = pair;
        hdr_nxt   = hdr_sent;
        case (state)
            IDLE: begin
                bit_nxt = '0;
                if (!fifo_empty) begin
                    if (HEADER_EN != 0 && !pair && !hdr_sent) begin
                        shreg_nxt = HEADER;
                        hdr_nxt   = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = READ;
                    end
                end
            end
            READ:  state_nxt = LATCH;
            LATCH: begin
                shreg_nxt = fifo_dout;
                pair_nxt  = ~pair;
                hdr_nxt   = 1'b0;
                state_nxt = START;
            end
            START: if (tick) state_nxt = DATA;
            DATA: begin
                if (tick) begin
                    shreg_nxt = {1'b0, shreg[7:1]};
                    bit_nxt   = bit_cnt + 3'd1;   // wraps to 0 after bit 7
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == STOP_LAST) begin
                        bit_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx is registered from next-state values so the pin is glitch-free
    // yet still lines up with the state it belongs to.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            pair     <= 1'b0;
            hdr_sent <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_nxt;
            pair     <= pair_nxt;
            hdr_sent <= hdr_nxt;
            tx       <= tx_nxt;
        end
    end

    assign fifo_rd_en = (state == READ);
    assign busy       = (state != IDLE);
    assign byte_done  = (state == STOP) && tick && (bit_cnt == STOP_LAST);

endmodule
